alu_seq: RTL

- Parametrised, registered successor to the combinational ALU, with a start/busy/done handshake.
- Single-cycle logic, arithmetic and shift ops, plus an iterative signed shift-add multiplier that takes WIDTH+1 cycles.
- Has dedicated carry and multiply-high registers; MUL does not reuse the carry flag.
- Sits between the register file and the writeback mux. The state machine issues `start` and waits for `done` instead of using exec phases.

---
 rtl/alu_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered ALU with start/busy/done handshake and an iterative
//            signed shift-add multiplier (WIDTH+1 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             carry,
    output logic             zero,
    output logic             neg
);

    localparam logic [3:0] OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_XOR = 4'd2,  OP_NOT = 4'd3;
    localparam logic [3:0] OP_MOV = 4'd4,  OP_ADD = 4'd5,  OP_ADC = 4'd6,  OP_SUB = 4'd7;
    localparam logic [3:0] OP_SBC = 4'd8,  OP_INC = 4'd9,  OP_DEC = 4'd10, OP_LSL = 4'd11;
    localparam logic [3:0] OP_LSR = 4'd12, OP_ASR = 4'd13, OP_MUL = 4'd14, OP_MRT = 4'd15;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULI = 2'd1;
    localparam logic [1:0] S_MFIN = 2'd2;

    localparam logic [WIDTH-1:0] WIDTH_B = WIDTH'(WIDTH);

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   mul_hi_q, mul_hi_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;
    logic               carry_q,  carry_d;
    logic               zero_q,   zero_d;
    logic               neg_q,    neg_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               sign_q,   sign_d;
    logic [CW-1:0]      cnt_q,    cnt_d;

    logic [WIDTH-1:0]   alu_res_w;
    logic [WIDTH:0]     sum_w;
    logic               wr_carry_w;
    logic               shamt_big_w;
    logic [WIDTH-1:0]   mag_a_w, mag_b_w;
    logic [2*WIDTH-1:0] prod_w;

    // Magnitudes as unsigned: the most-negative value negates to itself,
    // which read unsigned is exactly 2^(WIDTH-1).
    assign mag_a_w     = a[WIDTH-1] ? -a : a;
    assign mag_b_w     = b[WIDTH-1] ? -b : b;
    assign prod_w      = sign_q ? -acc_q : acc_q;
    assign shamt_big_w = (b >= WIDTH_B);

    always_comb begin
        sum_w      = '0;
        alu_res_w  = '0;
        wr_carry_w = 1'b0;
        case (op)
            OP_AND: alu_res_w = a & b;
            OP_OR:  alu_res_w = a | b;
            OP_XOR: alu_res_w = a ^ b;
            OP_NOT: alu_res_w = ~a;
            OP_MOV: alu_res_w = a;
            OP_ADD: begin
                sum_w      = {1'b0, a} + {1'b0, b};
                wr_carry_w = 1'b1;
            end
            OP_ADC: begin
                sum_w      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
                wr_carry_w = 1'b1;
            end
            OP_SUB: begin
                sum_w      = {1'b0, a} - {1'b0, b};
                wr_carry_w = 1'b1;
            end
            OP_SBC: begin
                sum_w      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_q};
                wr_carry_w = 1'b1;
            end
            OP_INC: begin
                sum_w      = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                wr_carry_w = 1'b1;
            end
            OP_DEC: begin
                sum_w      = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
                wr_carry_w = 1'b1;
            end
            OP_LSL: alu_res_w = shamt_big_w ? '0 : (a << b);
            OP_LSR: alu_res_w = shamt_big_w ? '0 : (a >> b);
            OP_ASR: alu_res_w = shamt_big_w ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
            OP_MRT: alu_res_w = mul_hi_q;
            default: alu_res_w = '0;
        endcase
        if (wr_carry_w) begin
            alu_res_w = sum_w[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        mul_hi_d = mul_hi_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, mag_a_w};
                        mplier_d = mag_b_w;
                        acc_d    = '0;
                        sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        cnt_d    = CW'(WIDTH);
                        busy_d   = 1'b1;
                        state_d  = S_MULI;
                    end else begin
                        result_d = alu_res_w;
                        zero_d   = (alu_res_w == '0);
                        neg_d    = alu_res_w[WIDTH-1];
                        done_d   = 1'b1;
                        if (wr_carry_w) begin
                            carry_d = sum_w[WIDTH];
                        end
                    end
                end
            end
            S_MULI: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_MFIN;
                end
            end
            S_MFIN: begin
                result_d = prod_w[WIDTH-1:0];
                mul_hi_d = prod_w[2*WIDTH-1:WIDTH];
                zero_d   = (prod_w[WIDTH-1:0] == '0);
                neg_d    = prod_w[WIDTH-1];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            mul_hi_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            mul_hi_q <= mul_hi_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign neg    = neg_q;

endmodule
`default_nettype wire
